// File: rtl/ddram_responder.sv
// ddram_responder
//   Target end of the core's 64-bit DDRAM bus, backed by on-chip block RAM.
//   Serves burst reads with a fixed latency and burst writes with byte
//   enables. Optional periodic BUSY injection exercises initiator
//   back-pressure.
//
// Ports
//   CLK_50M           in   sole clock, rising edge
//   RESET             in   asynchronous, active-high
//   DDRAM_ADDR        in   64-bit word address (low ADDR_W bits used)
//   DDRAM_BURSTCNT    in   burst length in beats (0 behaves as 1)
//   DDRAM_RD          in   read request
//   DDRAM_WE          in   write request / write beat valid
//   DDRAM_DIN         in   write data
//   DDRAM_BE          in   byte enables, bit i covers DIN[8i+7:8i]
//   DDRAM_BUSY        out  wait-request
//   DDRAM_DOUT        out  read data, holds last beat
//   DDRAM_DOUT_READY  out  one-cycle strobe per read beat
//   proto_err         out  sticky protocol-error flag
`timescale 1ns/1ps

module ddram_responder #(
    parameter int ADDR_W      = 12,
    parameter int RD_LATENCY  = 4,
    parameter int BUSY_PERIOD = 0
) (
    input  logic        CLK_50M,
    input  logic        RESET,
    input  logic [28:0] DDRAM_ADDR,
    input  logic [3:0]  DDRAM_BURSTCNT,
    input  logic        DDRAM_RD,
    input  logic        DDRAM_WE,
    input  logic [63:0] DDRAM_DIN,
    input  logic [7:0]  DDRAM_BE,
    output logic        DDRAM_BUSY,
    output logic [63:0] DDRAM_DOUT,
    output logic        DDRAM_DOUT_READY,
    output logic        proto_err
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_BURST, WR_BURST} state_e;

    // The accept edge and the first RD_BURST edge together account for two
    // cycles of the latency; the wait counter covers the rest.
    localparam logic [3:0] LAT_LOAD = 4'(RD_LATENCY - 2);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          beats_q, beats_d;
    logic [3:0]          lat_q, lat_d;
    logic                busy_q, busy_d;
    logic                rdy_q;
    logic [63:0]         dout_q;
    logic                err_q, err_d;

    logic [3:0]          eff_cnt;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_wa;
    logic                inj_next;
    logic [7:0][7:0]     rd_word;

    logic                unused_addr;
    assign unused_addr = ^DDRAM_ADDR[28:ADDR_W];

    //------------------------------------------------------------------
    // BUSY injection: free-running counter; inj_next is high when the
    // count for the coming cycle is the last value of the period.
    //------------------------------------------------------------------
    generate
        if (BUSY_PERIOD > 0) begin : g_inj
            localparam int INJ_W = (BUSY_PERIOD > 1) ? $clog2(BUSY_PERIOD) : 1;
            localparam logic [INJ_W-1:0] INJ_LAST = INJ_W'(BUSY_PERIOD - 1);
            logic [INJ_W-1:0] inj_cnt_q, inj_cnt_d;

            assign inj_cnt_d = (inj_cnt_q == INJ_LAST) ? '0 : inj_cnt_q + INJ_W'(1);
            assign inj_next  = (inj_cnt_d == INJ_LAST);

            always_ff @(posedge CLK_50M or posedge RESET) begin
                if (RESET) inj_cnt_q <= '0;
                else       inj_cnt_q <= inj_cnt_d;
            end
        end else begin : g_no_inj
            assign inj_next = 1'b0;
        end
    endgenerate

    //------------------------------------------------------------------
    // Next-state logic
    //------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        beats_d = beats_q;
        lat_d   = lat_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        mem_wa  = addr_q;
        eff_cnt = (DDRAM_BURSTCNT == 4'd0) ? 4'd1 : DDRAM_BURSTCNT;

        unique case (state_q)
            IDLE: begin
                if (DDRAM_RD && DDRAM_WE) err_d = 1'b1;
                // Write wins when both are requested; the read is dropped.
                if (!busy_q && DDRAM_WE) begin
                    mem_we  = 1'b1;
                    mem_wa  = DDRAM_ADDR[ADDR_W-1:0];
                    addr_d  = DDRAM_ADDR[ADDR_W-1:0] + ADDR_W'(1);
                    beats_d = eff_cnt - 4'd1;
                    if (DDRAM_BURSTCNT == 4'd0) err_d = 1'b1;
                    if (eff_cnt != 4'd1) state_d = WR_BURST;
                end else if (!busy_q && DDRAM_RD) begin
                    addr_d  = DDRAM_ADDR[ADDR_W-1:0];
                    beats_d = eff_cnt;
                    lat_d   = LAT_LOAD;
                    if (DDRAM_BURSTCNT == 4'd0) err_d = 1'b1;
                    state_d = RD_WAIT;
                end
            end

            RD_WAIT: begin
                if (DDRAM_RD || DDRAM_WE) err_d = 1'b1;
                if (lat_q == 4'd0) state_d = RD_BURST;
                else               lat_d   = lat_q - 4'd1;
            end

            RD_BURST: begin
                if (DDRAM_RD || DDRAM_WE) err_d = 1'b1;
                addr_d  = addr_q + ADDR_W'(1);
                beats_d = beats_q - 4'd1;
                if (beats_q == 4'd1) state_d = IDLE;
            end

            WR_BURST: begin
                if (DDRAM_RD) err_d = 1'b1;
                // A beat held through BUSY lands on the next non-busy cycle.
                if (DDRAM_WE && !busy_q) begin
                    mem_we  = 1'b1;
                    mem_wa  = addr_q;
                    addr_d  = addr_q + ADDR_W'(1);
                    beats_d = beats_q - 4'd1;
                    if (beats_q == 4'd1) state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        // BUSY covers the whole read plus the cycle after the last beat
        // (state_q==RD_BURST term); injection applies only in IDLE/WR_BURST.
        busy_d = (state_d == RD_WAIT) || (state_d == RD_BURST) ||
                 (state_q == RD_BURST) ||
                 (inj_next && ((state_d == IDLE) || (state_d == WR_BURST)));
    end

    //------------------------------------------------------------------
    // Backing store: one byte-wide array per lane so byte enables map
    // directly onto independent write strobes. Not reset.
    //------------------------------------------------------------------
    generate
        for (genvar b = 0; b < 8; b++) begin : g_lane
            logic [7:0] mem_b [0:(1<<ADDR_W)-1];

            always_ff @(posedge CLK_50M) begin
                if (mem_we && !RESET && DDRAM_BE[b])
                    mem_b[mem_wa] <= DDRAM_DIN[8*b +: 8];
            end

            assign rd_word[b] = mem_b[addr_q];
        end
    endgenerate

    //------------------------------------------------------------------
    // State and output registers
    //------------------------------------------------------------------
    always_ff @(posedge CLK_50M or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            addr_q  <= '0;
            beats_q <= '0;
            lat_q   <= '0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
            dout_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            beats_q <= beats_d;
            lat_q   <= lat_d;
            busy_q  <= busy_d;
            rdy_q   <= (state_q == RD_BURST);
            err_q   <= err_d;
            // Output register doubles as the RAM read register; holds
            // the last beat between bursts.
            if (state_q == RD_BURST) dout_q <= rd_word;
        end
    end

    assign DDRAM_BUSY       = busy_q;
    assign DDRAM_DOUT       = dout_q;
    assign DDRAM_DOUT_READY = rdy_q;
    assign proto_err        = err_q;

endmodule

// File: tb/tb_ddram_responder.sv
`timescale 1ns/1ps

module tb_ddram_responder;

    localparam int AW = 4;
    localparam int L0 = 4;
    localparam int L1 = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [28:0] addr;
    logic [3:0]  bcnt;
    logic        rd, we;
    logic [63:0] din;
    logic [7:0]  be;

    logic        busy0, rdy0, err0;
    logic [63:0] dout0;
    logic        busy1, rdy1, err1;
    logic [63:0] dout1;

    int n_chk  = 0;
    int n_fail = 0;

    logic [63:0] q0[$];
    logic [63:0] q1[$];
    logic [63:0] mdl0 [16];
    logic [63:0] mdl1 [16];
    bit          mon0_en = 1'b1;
    bit          mon1_en = 1'b0;

    always #5 clk = ~clk;

    ddram_responder #(.ADDR_W(AW), .RD_LATENCY(L0), .BUSY_PERIOD(0)) u_dut (
        .CLK_50M(clk), .RESET(rst), .DDRAM_ADDR(addr), .DDRAM_BURSTCNT(bcnt),
        .DDRAM_RD(rd), .DDRAM_WE(we), .DDRAM_DIN(din), .DDRAM_BE(be),
        .DDRAM_BUSY(busy0), .DDRAM_DOUT(dout0), .DDRAM_DOUT_READY(rdy0),
        .proto_err(err0)
    );

    ddram_responder #(.ADDR_W(AW), .RD_LATENCY(L1), .BUSY_PERIOD(3)) u_bp (
        .CLK_50M(clk), .RESET(rst), .DDRAM_ADDR(addr), .DDRAM_BURSTCNT(bcnt),
        .DDRAM_RD(rd), .DDRAM_WE(we), .DDRAM_DIN(din), .DDRAM_BE(be),
        .DDRAM_BUSY(busy1), .DDRAM_DOUT(dout1), .DDRAM_DOUT_READY(rdy1),
        .proto_err(err1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: read beats popped and compared as they appear.
    always @(negedge clk) begin
        if (mon0_en && rdy0) begin
            chk("rd0_beat_expected", 64'(q0.size() != 0), 64'd1);
            if (q0.size() != 0) chk("rd0_data", dout0, q0.pop_front());
        end
        if (mon1_en && rdy1) begin
            chk("rd1_beat_expected", 64'(q1.size() != 0), 64'd1);
            if (q1.size() != 0) chk("rd1_data", dout1, q1.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? busy0 : busy1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        #1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic wait_idle(input int sel, input string tag);
        int t = 0;
        while (get_busy(sel) && t < 50) begin
            step();
            t++;
        end
        if (t >= 50) chk(tag, 64'(get_busy(sel)), 64'd0);
    endtask

    // Burst write holding each beat until accepted; beat k carries base+k.
    task automatic wr(input int sel, input logic [3:0] a, input logic [3:0] n,
                      input logic [63:0] base, input logic [7:0] bmask);
        int         nb;
        int         t;
        logic       acc;
        logic [3:0] wa;
        logic [63:0] d;
        nb = (n == 4'd0) ? 1 : int'(n);
        wait_idle(sel, "wr_idle_timeout");
        addr = 29'(a);
        bcnt = n;
        be   = bmask;
        we   = 1'b1;
        for (int k = 0; k < nb; k++) begin
            d   = base + 64'(k);
            din = d;
            wa  = a + 4'(k);
            t   = 0;
            acc = 1'b0;
            while (!acc && t < 50) begin
                acc = !get_busy(sel);
                step();
                t++;
            end
            if (!acc) chk("wr_beat_timeout", 64'(acc), 64'd1);
            for (int i = 0; i < 8; i++) begin
                if (bmask[i]) begin
                    if (sel == 0) mdl0[wa][8*i +: 8] = d[8*i +: 8];
                    else          mdl1[wa][8*i +: 8] = d[8*i +: 8];
                end
            end
        end
        we = 1'b0;
    endtask

    // Read on the no-injection DUT with exact cycle timing of BUSY/READY.
    task automatic rd0(input logic [3:0] a, input logic [3:0] n, input string tag);
        int         nb;
        logic [3:0] ra;
        nb = (n == 4'd0) ? 1 : int'(n);
        wait_idle(0, "rd0_idle_timeout");
        addr = 29'(a);
        bcnt = n;
        rd   = 1'b1;
        for (int k = 0; k < nb; k++) begin
            ra = a + 4'(k);
            q0.push_back(mdl0[ra]);
        end
        step();
        rd = 1'b0;
        chk({tag, "_busy_acc"}, 64'(busy0), 64'd1);
        chk({tag, "_rdy_acc"},  64'(rdy0),  64'd0);
        for (int j = 1; j <= L0 + nb; j++) begin
            step();
            chk({tag, "_rdy"},  64'(rdy0),  64'(j >= L0 && j < L0 + nb));
            chk({tag, "_busy"}, 64'(busy0), 64'(j < L0 + nb));
        end
    endtask

    task automatic rd1(input logic [3:0] a, input logic [3:0] n);
        int         nb;
        int         t;
        logic       acc;
        logic [3:0] ra;
        nb = (n == 4'd0) ? 1 : int'(n);
        addr = 29'(a);
        bcnt = n;
        rd   = 1'b1;
        for (int k = 0; k < nb; k++) begin
            ra = a + 4'(k);
            q1.push_back(mdl1[ra]);
        end
        t   = 0;
        acc = 1'b0;
        while (!acc && t < 50) begin
            acc = !busy1;
            step();
            t++;
        end
        rd = 1'b0;
        chk("rd1_accept", 64'(acc), 64'd1);
        t = 0;
        while (q1.size() != 0 && t < 60) begin
            step();
            t++;
        end
        chk("rd1_drain", 64'(q1.size()), 64'd0);
    endtask

    initial begin
        int c;
        rst  = 1'b1;
        addr = '0;
        bcnt = '0;
        rd   = 1'b0;
        we   = 1'b0;
        din  = '0;
        be   = '0;
        repeat (3) step();

        // Reset state
        chk("rst_busy", 64'(busy0), 64'd0);
        chk("rst_rdy",  64'(rdy0),  64'd0);
        chk("rst_dout", dout0,      64'd0);
        chk("rst_err",  64'(err0),  64'd0);
        rst = 1'b0;
        step();

        // Latency; read issued the cycle after the write beat
        wr(0, 4'd5, 4'd1, 64'h1122334455667788, 8'hFF);
        rd0(4'd5, 4'd1, "lat");

        // Burst write across the top of a 16-word store, read back
        wr(0, 4'd14, 4'd4, 64'hA0, 8'hFF);
        rd0(4'd14, 4'd4, "wrap");
        rd0(4'd0, 4'd1, "wrap0");

        // Byte enables
        wr(0, 4'd3, 4'd1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        wr(0, 4'd3, 4'd1, 64'h0, 8'h0F);
        rd0(4'd3, 4'd1, "be");
        chk("err_clean", 64'(err0), 64'd0);

        // RD+WE together: write taken, read dropped
        wait_idle(0, "rdwe_idle_timeout");
        addr = 29'd7;
        bcnt = 4'd1;
        din  = 64'h5555_AAAA_1234_5678;
        be   = 8'hFF;
        rd   = 1'b1;
        we   = 1'b1;
        step();
        rd = 1'b0;
        we = 1'b0;
        mdl0[7] = 64'h5555_AAAA_1234_5678;
        c = 0;
        repeat (L0 + 3) begin
            step();
            c += int'(rdy0);
        end
        chk("rdwe_no_beat", 64'(c), 64'd0);
        chk("rdwe_err", 64'(err0), 64'd1);
        rd0(4'd7, 4'd1, "rdwe_data");

        // BURSTCNT=0 read: one beat, error flagged
        do_reset();
        chk("err_cleared", 64'(err0), 64'd0);
        rd0(4'd5, 4'd0, "bc0");
        chk("bc0_err", 64'(err0), 64'd1);

        // Reset during beat 2 of an 8-beat read
        do_reset();
        wr(0, 4'd8, 4'd8, 64'hC0, 8'hFF);
        wait_idle(0, "mid_idle_timeout");
        addr = 29'd8;
        bcnt = 4'd8;
        rd   = 1'b1;
        for (int k = 0; k < 8; k++) q0.push_back(mdl0[8 + k]);
        step();
        rd = 1'b0;
        repeat (L0 + 2) step();
        chk("mid_rdy_pre", 64'(rdy0), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rdy",  64'(rdy0),  64'd0);
        chk("mid_busy", 64'(busy0), 64'd0);
        chk("mid_dout", dout0,      64'd0);
        chk("mid_popped", 64'(q0.size()), 64'd6);
        q0.delete();
        step();
        rst = 1'b0;
        step();
        rd0(4'd9, 4'd2, "post_rst");
        chk("q0_empty", 64'(q0.size()), 64'd0);

        // Back-pressure on the injecting instance
        mon0_en = 1'b0;
        do_reset();
        mon1_en = 1'b1;
        c = 0;
        repeat (9) begin
            step();
            c += int'(busy1);
        end
        chk("inj_count", 64'(c), 64'd3);
        wr(1, 4'd2, 4'd6, 64'hB0, 8'hFF);
        rd1(4'd2, 4'd6);
        chk("bp_err", 64'(err1), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ddram_responder.md
# ddram_responder

Avalon-MM style responder for the core's DDRAM port: the target end of the 64-bit DDRAM_ADDR / BURSTCNT / RD / WE / BUSY / DOUT_READY bus that the PGM core drives. It is backed by on-chip block RAM. It serves burst reads with a fixed, programmable latency and accepts burst writes with byte enables. Optional periodic BUSY injection exercises initiator back-pressure. It sits in place of the framework DDR3 bridge in bench and standalone builds.

## Interface
Parameters:
- ADDR_W, 12 — backing store depth is 2^ADDR_W 64-bit words.
- RD_LATENCY, 4 — cycles from read accept edge to first DOUT_READY beat; legal range 2..15.
- BUSY_PERIOD, 0 — 0 disables injection; N>0 forces BUSY high for one cycle every N cycles while in IDLE or WR_BURST.

Ports:
- CLK_50M  in  1 — sole clock; all logic on rising edge.
- RESET  in  1 — asynchronous, active-high reset.
- DDRAM_ADDR  in  29 — 64-bit word address; only [ADDR_W-1:0] are used.
- DDRAM_BURSTCNT  in  4 — burst length in beats; 0 is treated as 1.
- DDRAM_RD  in  1 — read request.
- DDRAM_WE  in  1 — write request / write beat valid.
- DDRAM_DIN  in  64 — write data.
- DDRAM_BE  in  8 — byte enables; bit i covers DIN[8i+7:8i].
- DDRAM_BUSY  out  1 — wait-request; a request or beat is accepted only on an edge where it is high while BUSY=0.
- DDRAM_DOUT  out  64 — read data.
- DDRAM_DOUT_READY  out  1 — read beat valid, one cycle per beat.
- proto_err  out  1 — sticky protocol-error flag, cleared only by RESET.

## Operation
- States: IDLE, RD_WAIT, RD_BURST, WR_BURST.
- IDLE with RD=1, WE=0, !BUSY:
  - Latch addr = ADDR[ADDR_W-1:0] and beats = (BURSTCNT==0 ? 1 : BURSTCNT).
  - Load the latency counter with RD_LATENCY-2, then go to RD_WAIT.
- RD_WAIT: counter decrements each cycle; at 0 go to RD_BURST.
- RD_BURST:
  - Each cycle, present mem[addr] with DOUT_READY=1, then addr++ (mod 2^ADDR_W) and beats--.
  - After the last beat, go to IDLE.
- IDLE with WE=1, !BUSY:
  - Write the first beat: for each i with BE[i]=1, mem[ADDR][byte i] = DIN byte i.
  - Latch addr+1 and beats-1.
  - If the remainder is 0, stay in IDLE; otherwise go to WR_BURST.
- WR_BURST:
  - Each accepted beat (WE && !BUSY) writes DIN under BE at addr, then addr++ (wrapping) and beats--.
  - After the last beat, go to IDLE.
  - ADDR and BURSTCNT are ignored in this state.
- Protocol errors set proto_err:
  - RD and WE both high in IDLE: the write is taken, the read is dropped.
  - RD high in WR_BURST: ignored.
  - RD or WE high while in RD_WAIT/RD_BURST: ignored; BUSY is high, so it is not accepted anyway.
  - BURSTCNT==0 on an accepted command.
- Read-after-write: a read accepted the cycle after a write beat returns the new data.
- Backing memory is not cleared by reset; its contents are undefined until written.

## Timing
- Reset values: BUSY=0, DOUT_READY=0, DOUT=0, proto_err=0, state=IDLE, injection counter=0.
- All outputs are registered.
- Read accepted on edge N:
  - BUSY=1 from edge N through the edge that presents the last beat.
  - Beat k (k=0..beats-1) has DOUT_READY=1 after edge N+RD_LATENCY+k.
  - BUSY returns to 0 after edge N+RD_LATENCY+beats.
- DOUT holds its last beat value when DOUT_READY=0.
- Writes have zero added latency; one beat is accepted per cycle when BUSY=0.
- Injection:
  - A free-running counter (0..BUSY_PERIOD-1) raises BUSY for the cycle where the count is BUSY_PERIOD-1, only in IDLE/WR_BURST.
  - During WR_BURST the held beat is written on the next non-busy cycle.
- RESET mid-burst: the state machine returns to IDLE immediately; remaining read beats are not issued and remaining write beats are not expected. Bytes already written stay written.

## Test plan
- Read latency, RD_LATENCY=4: write 0x1122334455667788 at addr 5 (BE=FF), then read addr 5 with BURSTCNT=1 accepted on edge N → DOUT_READY only after edge N+4 with that data; BUSY=0 from N+5.
- Burst and wrap, ADDR_W=4: write 4-beat burst at addr 14 with data 0xA0..0xA3 → read of addr 14 BURSTCNT=4 returns A0,A1,A2,A3 on consecutive cycles; addr 0 holds A2.
- Byte enables: write 0xFFFF...FF, then write 0x0 with BE=0x0F at the same addr → reads back 0xFFFFFFFF00000000.
- Back-pressure, BUSY_PERIOD=3: 6-beat write burst with the initiator holding WE/DIN through BUSY → all 6 words correct; BUSY pulses once every 3 cycles.
- Errors: RD+WE together in IDLE → write occurs, no DOUT_READY, proto_err=1; BURSTCNT=0 read → exactly 1 beat, proto_err=1.
- Reset mid-read: assert RESET during RD_BURST beat 2 of 8 → DOUT_READY=0 and BUSY=0 immediately; a subsequent read works normally.
